cdb_arbiter: RTL

- Parametrised common-data-bus arbiter for the Tomasulo core, replacing the fixed adder/multiplier/memory broadcast mux.
- Accepts results from NUM_SRC functional-unit ports through per-source FIFOs with a valid/ready handshake, so no result is lost when several units complete together.
- Broadcasts one {tag, data} per cycle to the reservation stations and register file with no idle gap between broadcasts.
- Supports fixed-priority or round-robin arbitration, plus a flush for pipeline squash.

---
 rtl/cdb_arbiter.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs feed one registered {tag, data}
// broadcast per cycle, chosen by fixed priority or round robin, with synchronous flush.

module cdb_arbiter_checker #(
  parameter int NUM_SRC    = 8,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input logic                                      clk,
  input logic                                      reset,
  input logic                                      flush,
  input logic [NUM_SRC-1:0]                        src_ready,
  input logic                                      cdb_valid,
  input logic [DATA_W-1:0]                         cdb_data,
  input logic [TAG_W-1:0]                          cdb_tag,
  input logic [$clog2(NUM_SRC)-1:0]                cdb_src,
  input logic [NUM_SRC*($clog2(FIFO_DEPTH)+1)-1:0] fifo_occupancy
);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  a_flush_kills_bus: assert property (@(posedge clk) disable iff (reset)
    flush |=> !cdb_valid);

  a_idle_bus_zero: assert property (@(posedge clk) disable iff (reset)
    !cdb_valid |-> (cdb_data == '0 && cdb_tag == '0 && cdb_src == '0));

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_occ_chk
    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
      fifo_occupancy[g*OCC_W +: OCC_W] <= OCC_W'(FIFO_DEPTH));
    a_ready_is_not_full: assert property (@(posedge clk) disable iff (reset)
      src_ready[g] == (fifo_occupancy[g*OCC_W +: OCC_W] != OCC_W'(FIFO_DEPTH)));
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_SRC    = 8,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int RR_MODE    = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic [NUM_SRC-1:0]                        src_valid,
  output logic [NUM_SRC-1:0]                        src_ready,
  input  logic [NUM_SRC*DATA_W-1:0]                 src_data,
  input  logic [NUM_SRC*TAG_W-1:0]                  src_tag,
  output logic                                      cdb_valid,
  output logic [DATA_W-1:0]                         cdb_data,
  output logic [TAG_W-1:0]                          cdb_tag,
  output logic [$clog2(NUM_SRC)-1:0]                cdb_src,
  output logic [NUM_SRC*($clog2(FIFO_DEPTH)+1)-1:0] fifo_occupancy
);
  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + DATA_W;

  logic [ENT_W-1:0]   r_mem    [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr [NUM_SRC];
  logic [PTR_W-1:0]   r_rd_ptr [NUM_SRC];
  logic [OCC_W-1:0]   r_occ    [NUM_SRC];
  logic [IDX_W-1:0]   r_rr_ptr;

  logic               r_cdb_valid;
  logic [DATA_W-1:0]  r_cdb_data;
  logic [TAG_W-1:0]   r_cdb_tag;
  logic [IDX_W-1:0]   r_cdb_src;

  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_cand;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic               w_grant_vld;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [IDX_W:0]     w_rr_sum;
  logic [ENT_W-1:0]   w_head;

  // Full/non-empty status derived purely from occupancy
  always_comb begin
    w_full = '0;
    w_cand = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_full[i] = (r_occ[i] == OCC_W'(FIFO_DEPTH));
      w_cand[i] = (r_occ[i] != OCC_W'(0));
    end
  end

  // Grant selection; loops run in reverse so the last hit is the first in search order
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_rr_sum    = '0;
    if (RR_MODE != 0) begin
      for (int k = NUM_SRC; k >= 1; k--) begin
        w_rr_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
        if (w_rr_sum >= (IDX_W+1)'(NUM_SRC)) begin
          w_rr_sum = w_rr_sum - (IDX_W+1)'(NUM_SRC);
        end else begin
          w_rr_sum = w_rr_sum;
        end
        if (w_cand[w_rr_sum[IDX_W-1:0]]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_rr_sum[IDX_W-1:0];
        end else begin
          w_grant_idx = w_grant_idx;
        end
      end
    end else begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (w_cand[i]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = IDX_W'(i);
        end else begin
          w_grant_idx = w_grant_idx;
        end
      end
    end
  end

  // Handshake qualification; flush overrides both push and pop
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_push[i] = src_valid[i] & ~w_full[i] & ~flush;
      w_pop[i]  = w_grant_vld & (w_grant_idx == IDX_W'(i)) & ~flush;
    end
  end

  assign w_head = r_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_occ[i]    <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_occ[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_push[i]) begin
          r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
        end else begin
          r_wr_ptr[i] <= r_wr_ptr[i];
        end
        if (w_pop[i]) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
        end else begin
          r_rd_ptr[i] <= r_rd_ptr[i];
        end
        case ({w_push[i], w_pop[i]})
          2'b10:   r_occ[i] <= r_occ[i] + OCC_W'(1);
          2'b01:   r_occ[i] <= r_occ[i] - OCC_W'(1);
          default: r_occ[i] <= r_occ[i];
        endcase
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          r_mem[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_push[i]) begin
          r_mem[i][r_wr_ptr[i]] <= {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
        end else begin
          r_mem[i][r_wr_ptr[i]] <= r_mem[i][r_wr_ptr[i]];
        end
      end
    end
  end

  // Round-robin pointer follows the last grant; a flush leaves it untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= IDX_W'(NUM_SRC - 1);
    end else if (!flush && w_grant_vld) begin
      r_rr_ptr <= w_grant_idx;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // Registered broadcast; idle cycles drive zeros
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cdb_valid <= 1'b0;
      r_cdb_data  <= '0;
      r_cdb_tag   <= '0;
      r_cdb_src   <= '0;
    end else if (!flush && w_grant_vld) begin
      r_cdb_valid <= 1'b1;
      r_cdb_data  <= w_head[DATA_W-1:0];
      r_cdb_tag   <= w_head[ENT_W-1:DATA_W];
      r_cdb_src   <= w_grant_idx;
    end else begin
      r_cdb_valid <= 1'b0;
      r_cdb_data  <= '0;
      r_cdb_tag   <= '0;
      r_cdb_src   <= '0;
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_data  = r_cdb_data;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_src   = r_cdb_src;
  assign src_ready = ~w_full;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_occ
    assign fifo_occupancy[g*OCC_W +: OCC_W] = r_occ[g];
  end

  cdb_arbiter_checker #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_chk (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .src_ready      (src_ready),
    .cdb_valid      (cdb_valid),
    .cdb_data       (cdb_data),
    .cdb_tag        (cdb_tag),
    .cdb_src        (cdb_src),
    .fifo_occupancy (fifo_occupancy)
  );
endmodule
